// File: rtl/encode_mul_pipe.sv
`default_nettype none
// ============================================================================
// Module   : encode_mul_pipe
// Purpose  : Parametrised pipelined multiplier for the ADPCM encode datapath.
//            Per-operation signed/unsigned mode and a full-width product.
//            Narrowing uses an arithmetic right shift with optional
//            round-half-up, then a wrap (or clamp) to OUT_WIDTH.
//            Valid and tag sideband bits travel alongside the data.
//            A single clock enable stalls every register in the pipe.
// Ports    : clk, reset (async, active-low), ce, in_valid, in_signed,
//            din0[A_WIDTH], din1[B_WIDTH], in_tag[TAG_WIDTH]
//            -> out_valid, dout[OUT_WIDTH], out_tag[TAG_WIDTH], out_ovf
// Options  : define ENCODE_MUL_PIPE_SAT_EN to clamp dout on overflow instead
//            of wrapping. Latency is the same in both builds.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module encode_mul_pipe #(
    parameter int A_WIDTH   = 15,
    parameter int B_WIDTH   = 15,
    parameter int NUM_STAGE = 4,
    parameter int OUT_WIDTH = 30,
    parameter int SHIFT     = 0,
    parameter int ROUND     = 0,
    parameter int TAG_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ce,
    input  logic                 in_valid,
    input  logic                 in_signed,
    input  logic [A_WIDTH-1:0]   din0,
    input  logic [B_WIDTH-1:0]   din1,
    input  logic [TAG_WIDTH-1:0] in_tag,
    output logic                 out_valid,
    output logic [OUT_WIDTH-1:0] dout,
    output logic [TAG_WIDTH-1:0] out_tag,
    output logic                 out_ovf
);

    // Full product width: one guard bit so signed and unsigned products of
    // the extended operands are both exactly representable.
    localparam int c_W   = A_WIDTH + B_WIDTH + 1;
    localparam int c_RSH = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic [c_W:0] c_ONE = (c_W + 1)'(1);
    localparam logic [c_W:0] c_RND = (ROUND != 0 && SHIFT > 0) ? (c_ONE << c_RSH) : '0;
    localparam logic [OUT_WIDTH-1:0] c_UMAX = '1;
    localparam logic [OUT_WIDTH-1:0] c_SMAX = c_UMAX >> 1;
    localparam logic [OUT_WIDTH-1:0] c_SMIN = ~c_SMAX;

    generate
        if (!(A_WIDTH >= 1 && A_WIDTH <= 27 &&
              B_WIDTH >= 1 && B_WIDTH <= 18 &&
              NUM_STAGE >= 2 && NUM_STAGE <= 8 &&
              OUT_WIDTH >= 1 && OUT_WIDTH <= c_W &&
              SHIFT >= 0 && SHIFT <= A_WIDTH + B_WIDTH - 1 &&
              (ROUND == 0 || ROUND == 1) &&
              TAG_WIDTH >= 1)) begin : g_bad_params
            $error("encode_mul_pipe: illegal parameter combination");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Stage 1: operand capture
    // ------------------------------------------------------------------
    logic [A_WIDTH-1:0]   r_a;
    logic [B_WIDTH-1:0]   r_b;
    logic                 r_s1_sgn;
    logic                 r_s1_vld;
    logic [TAG_WIDTH-1:0] r_s1_tag;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_a      <= '0;
            r_b      <= '0;
            r_s1_sgn <= 1'b0;
            r_s1_vld <= 1'b0;
            r_s1_tag <= '0;
        end else if (ce) begin
            r_a      <= din0;
            r_b      <= din1;
            r_s1_sgn <= in_signed;
            r_s1_vld <= in_valid;
            r_s1_tag <= in_tag;
        end
    end

    // ------------------------------------------------------------------
    // Product: both operands extended to the full width according to the
    // mode, so the low c_W bits of an ordinary multiply are exact.
    // ------------------------------------------------------------------
    logic [c_W-1:0] w_a_ext;
    logic [c_W-1:0] w_b_ext;
    logic [c_W-1:0] w_prod;

    always_comb begin
        w_a_ext = {{(c_W - A_WIDTH){r_s1_sgn & r_a[A_WIDTH-1]}}, r_a};
        w_b_ext = {{(c_W - B_WIDTH){r_s1_sgn & r_b[B_WIDTH-1]}}, r_b};
        w_prod  = w_a_ext * w_b_ext;
    end

    // ------------------------------------------------------------------
    // Stages 2..NUM_STAGE-1 hold the product; with two stages the
    // narrowing logic feeds straight from the product.
    // ------------------------------------------------------------------
    logic [c_W-1:0]       w_fin_p;
    logic                 w_fin_vld;
    logic                 w_fin_sgn;
    logic [TAG_WIDTH-1:0] w_fin_tag;

    generate
        if (NUM_STAGE == 2) begin : g_direct
            assign w_fin_p   = w_prod;
            assign w_fin_vld = r_s1_vld;
            assign w_fin_sgn = r_s1_sgn;
            assign w_fin_tag = r_s1_tag;
        end else begin : g_delay
            localparam int c_D = NUM_STAGE - 2;
            logic [c_W-1:0]       r_p   [c_D];
            logic                 r_vld [c_D];
            logic                 r_sgn [c_D];
            logic [TAG_WIDTH-1:0] r_tag [c_D];

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    for (int i = 0; i < c_D; i++) begin
                        r_p[i]   <= '0;
                        r_vld[i] <= 1'b0;
                        r_sgn[i] <= 1'b0;
                        r_tag[i] <= '0;
                    end
                end else if (ce) begin
                    r_p[0]   <= w_prod;
                    r_vld[0] <= r_s1_vld;
                    r_sgn[0] <= r_s1_sgn;
                    r_tag[0] <= r_s1_tag;
                    for (int i = 1; i < c_D; i++) begin
                        r_p[i]   <= r_p[i-1];
                        r_vld[i] <= r_vld[i-1];
                        r_sgn[i] <= r_sgn[i-1];
                        r_tag[i] <= r_tag[i-1];
                    end
                end
            end

            assign w_fin_p   = r_p[c_D-1];
            assign w_fin_vld = r_vld[c_D-1];
            assign w_fin_sgn = r_sgn[c_D-1];
            assign w_fin_tag = r_tag[c_D-1];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Narrowing: round, shift, range check and wrap/clamp.
    // The extra top bit keeps the rounding add from overflowing. An
    // unsigned product always has a clear top bit, so sign-extending it is
    // harmless.
    // ------------------------------------------------------------------
    logic signed [c_W:0]  w_sum;
    logic signed [c_W:0]  w_r;
    logic signed [c_W:0]  w_hi_s;
    logic [c_W:0]         w_hi_u;
    logic                 w_ovf;
    logic [OUT_WIDTH-1:0] w_dout;

    always_comb begin
        w_sum  = $signed({w_fin_p[c_W-1], w_fin_p}) + $signed(c_RND);
        w_r    = w_sum >>> SHIFT;
        // Signed fit: everything from the output sign bit up is a copy of
        // the sign. Unsigned fit: nothing above the output MSB.
        w_hi_s = w_r >>> (OUT_WIDTH - 1);
        w_hi_u = w_r >> OUT_WIDTH;
        if (w_fin_sgn) begin
            w_ovf = (w_hi_s != '0) && (w_hi_s != '1);
        end else begin
            w_ovf = (w_hi_u != '0);
        end
        w_dout = w_r[OUT_WIDTH-1:0];
`ifdef ENCODE_MUL_PIPE_SAT_EN
        if (w_ovf) begin
            if (!w_fin_sgn) begin
                w_dout = c_UMAX;
            end else if (w_r[c_W]) begin
                w_dout = c_SMIN;
            end else begin
                w_dout = c_SMAX;
            end
        end
`else
        // Wrap build: the narrowed value is w_r[OUT_WIDTH-1:0] as set above.
        // The clamp limits are referenced only by the saturating build.
        if (1'b0 && (c_SMIN == c_UMAX)) begin
            w_dout = c_SMAX;
        end
`endif
    end

    // ------------------------------------------------------------------
    // Output stage
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            dout      <= '0;
            out_tag   <= '0;
            out_ovf   <= 1'b0;
        end else if (ce) begin
            out_valid <= w_fin_vld;
            dout      <= w_dout;
            out_tag   <= w_fin_tag;
            out_ovf   <= w_fin_vld & w_ovf;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_encode_mul_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_encode_mul_pipe
// Purpose  : Self-checking bench for encode_mul_pipe. Four instances share
//            one stimulus stream: the defaults, a rounding variant, a
//            truncating variant and a narrow no-shift variant. A behavioural
//            model checks every instance on every cycle. Directed literal
//            expectations pin the model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_encode_mul_pipe;

    localparam int NS = 4;
`ifdef ENCODE_MUL_PIPE_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct packed {
        logic        v;
        logic        s;
        logic [14:0] a;
        logic [14:0] b;
        logic [3:0]  t;
    } op_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ce = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_signed = 1'b0;
    logic [14:0] din0 = '0;
    logic [14:0] din1 = '0;
    logic [3:0]  in_tag = '0;

    logic        v0, v1, v2, v3;
    logic        o0, o1, o2, o3;
    logic [29:0] d0;
    logic [15:0] d1, d2, d3;
    logic [3:0]  t0, t1, t2, t3;

    int total = 0;
    int bad   = 0;
    bit run_cmp = 1'b0;

    always #5 clk = ~clk;

    encode_mul_pipe u_def (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_signed(in_signed),
        .din0(din0), .din1(din1), .in_tag(in_tag),
        .out_valid(v0), .dout(d0), .out_tag(t0), .out_ovf(o0));

    encode_mul_pipe #(.OUT_WIDTH(16), .SHIFT(15), .ROUND(1)) u_rnd (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_signed(in_signed),
        .din0(din0), .din1(din1), .in_tag(in_tag),
        .out_valid(v1), .dout(d1), .out_tag(t1), .out_ovf(o1));

    encode_mul_pipe #(.OUT_WIDTH(16), .SHIFT(15), .ROUND(0)) u_trunc (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_signed(in_signed),
        .din0(din0), .din1(din1), .in_tag(in_tag),
        .out_valid(v2), .dout(d2), .out_tag(t2), .out_ovf(o2));

    encode_mul_pipe #(.OUT_WIDTH(16)) u_narrow (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_signed(in_signed),
        .din0(din0), .din1(din1), .in_tag(in_tag),
        .out_valid(v3), .dout(d3), .out_tag(t3), .out_ovf(o3));

    // ------------------------------------------------------------------
    // Reference model: the list of operations sampled on ce edges since
    // reset; the result on the outputs is the one sampled NS ce edges ago.
    // ------------------------------------------------------------------
    op_t hist [0:4095];
    int  n = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            n <= 0;
        end else if (ce && n < 4095) begin
            hist[n] <= {in_valid, in_signed, din0, din1, in_tag};
            n       <= n + 1;
        end
    end

    function automatic void model(input op_t op, input int sh, input int rnd, input int ow,
                                  output longint dv, output logic ov);
        longint pa, pb, p, r, lo, hi;
        pa = longint'(op.a);
        pb = longint'(op.b);
        if (op.s && op.a[14]) pa = pa - 32768;
        if (op.s && op.b[14]) pb = pb - 32768;
        p = pa * pb;
        if (rnd != 0 && sh > 0) p = p + (longint'(1) << (sh - 1));
        r = p >>> sh;
        if (op.s) begin
            lo = -(longint'(1) << (ow - 1));
            hi = (longint'(1) << (ow - 1)) - 1;
        end else begin
            lo = 0;
            hi = (longint'(1) << ow) - 1;
        end
        ov = (r < lo) || (r > hi);
        if (SAT && ov) r = (r < lo) ? lo : hi;
        dv = r & ((longint'(1) << ow) - 1);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cmp_dut(input string nm, input int sh, input int rnd, input int ow,
                           input logic v, input logic [63:0] d, input logic [3:0] t,
                           input logic o);
        op_t    op;
        logic   ev;
        logic   eo;
        longint ed;
        if (!reset || n < NS) begin
            op = '0;
            ev = 1'b0;
        end else begin
            op = hist[n - NS];
            ev = op.v;
        end
        model(op, sh, rnd, ow, ed, eo);
        chk({nm, ".valid"}, 64'(v), 64'(ev));
        chk({nm, ".ovf"}, 64'(o), 64'(ev & eo));
        if (ev) begin
            chk({nm, ".tag"}, 64'(t), 64'(op.t));
            chk({nm, ".dout"}, d, ed);
        end else if (!reset) begin
            chk({nm, ".rst_dout"}, d, 64'd0);
            chk({nm, ".rst_tag"}, 64'(t), 64'd0);
        end
    endtask

    always @(negedge clk) begin
        if (run_cmp) begin
            cmp_dut("def",    0,  0, 30, v0, 64'(d0), t0, o0);
            cmp_dut("rnd",    15, 1, 16, v1, 64'(d1), t1, o1);
            cmp_dut("trunc",  15, 0, 16, v2, 64'(d2), t2, o2);
            cmp_dut("narrow", 0,  0, 16, v3, 64'(d3), t3, o3);
        end
    end

    function automatic logic [14:0] pick();
        case ($urandom_range(0, 5))
            0:       return 15'h0000;
            1:       return 15'h7FFF;
            2:       return 15'h4000;
            3:       return 15'h0001;
            default: return 15'($urandom);
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        op_t dir [5];
        int  seen [$];
        int  cyc;
        bit  done6;
        bit  ce_was;
        int  k;

        repeat (2) @(negedge clk);
        run_cmp = 1'b1;
        chk("reset.valid", 64'(v0), 64'd0);
        chk("reset.dout", 64'(d0), 64'd0);
        chk("reset.ovf", 64'(o0), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        ce    = 1'b1;

        // Directed back-to-back operations with literal results
        dir[0] = {1'b1, 1'b0, 15'h7FFF, 15'h7FFF, 4'd5};
        dir[1] = {1'b1, 1'b1, 15'h7FFF, 15'h0002, 4'd6};
        dir[2] = {1'b1, 1'b0, 15'h7FFF, 15'h0002, 4'd7};
        dir[3] = {1'b1, 1'b0, 15'h4000, 15'h0001, 4'd8};
        dir[4] = {1'b1, 1'b1, 15'h4000, 15'h0001, 4'd9};
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            case (c)
                4: begin
                    chk("lit.u_valid", 64'(v0), 64'd1);
                    chk("lit.u_dout", 64'(d0), 64'h3FFF0001);
                    chk("lit.u_ovf", 64'(o0), 64'd0);
                    chk("lit.u_tag", 64'(t0), 64'd5);
                    chk("lit.narrow_ovf", 64'(o3), 64'd1);
                    chk("lit.narrow_dout", 64'(d3), SAT ? 64'hFFFF : 64'h0001);
                end
                5: begin
                    chk("lit.s_dout", 64'(d0), 64'h3FFFFFFE);
                    chk("lit.s_tag", 64'(t0), 64'd6);
                end
                6: chk("lit.u2_dout", 64'(d0), 64'h0000FFFE);
                7: begin
                    chk("lit.rnd_pos", 64'(d1), 64'h0001);
                    chk("lit.trunc_pos", 64'(d2), 64'h0000);
                end
                8: begin
                    chk("lit.rnd_neg", 64'(d1), 64'h0000);
                    chk("lit.trunc_neg", 64'(d2), 64'hFFFF);
                end
                default: ;
            endcase
            if (c < 5) {in_valid, in_signed, din0, din1, in_tag} = dir[c];
            else in_valid = 1'b0;
        end

        // Stream of tags 1..6 with a three-cycle stall mid-stream
        cyc   = 0;
        done6 = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            cyc++;
            ce_was = ce;
            if (v0 && ce_was) seen.push_back(int'(t0));
            if (v0 && t0 == 4'd6 && !done6) begin
                done6 = 1'b1;
                chk("stall.cycles", 64'(cyc), 64'd13);
            end
            if (c == 7) begin
                chk("stall.hold_valid", 64'(v0), 64'd1);
                chk("stall.hold_tag", 64'(t0), 64'd2);
            end
            if (c < 5) begin
                ce = 1'b1; in_valid = 1'b1; in_tag = 4'(c + 1);
                in_signed = 1'($urandom_range(0, 1)); din0 = pick(); din1 = pick();
            end else if (c < 8) begin
                ce = 1'b0; in_valid = 1'b1; in_tag = 4'd6;
            end else if (c == 8) begin
                ce = 1'b1; in_valid = 1'b1; in_tag = 4'd6;
            end else begin
                ce = 1'b1; in_valid = 1'b0;
            end
        end
        chk("stall.seen6", 64'(done6), 64'd1);
        chk("stall.count", 64'(seen.size()), 64'd6);
        for (int i = 0; i < 6 && i < seen.size(); i++) begin
            chk("stall.order", 64'(seen[i]), 64'(i + 1));
        end

        // Reset with operations in flight
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            ce = 1'b1; in_valid = 1'b1; in_tag = 4'(c + 1);
            in_signed = 1'($urandom_range(0, 1)); din0 = pick(); din1 = pick();
            din0[0] = 1'b1; din1[0] = 1'b1;
        end
        @(posedge clk);
        #2;
        chk("rst.pre_valid", 64'(v0), 64'd1);
        reset = 1'b0;
        #1;
        chk("rst.async_valid", 64'(v0), 64'd0);
        chk("rst.async_dout", 64'(d0), 64'd0);
        chk("rst.async_ovf", 64'(o0), 64'd0);
        chk("rst.async_narrow_ovf", 64'(o3), 64'd0);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        in_valid = 1'b1; in_signed = 1'b0; din0 = 15'd3; din1 = 15'd5; in_tag = 4'd9;
        k = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (v0) begin
                k = i;
                break;
            end
        end
        chk("rst.new_latency", 64'(k), 64'd4);
        chk("rst.new_tag", 64'(t0), 64'd9);
        chk("rst.new_dout", 64'(d0), 64'd15);

        // Randomised traffic with random stalls and bubbles
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            ce        = ($urandom_range(0, 9) < 8);
            in_valid  = ($urandom_range(0, 9) < 7);
            in_signed = 1'($urandom_range(0, 1));
            din0      = pick();
            din1      = pick();
            in_tag    = 4'($urandom);
        end
        @(negedge clk);
        ce = 1'b1;
        in_valid = 1'b0;
        repeat (NS + 2) @(negedge clk);

        run_cmp = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
